vend_dispense_ctrl: RTL and testbench

- Downstream consumer of the coin sequence recogniser's `out` (vend) and `rtrn` (change) pulses.
- Converts each accepted sale into timed actuator drives: product motor, then change solenoid.
- Tracks product stock. On a sale while empty, it drives a refund instead of the motor.
- Holds one sale pending while busy, so back-to-back sales from the recogniser are never lost.

---
 rtl/vend_pkg.sv | 28 ++
 rtl/vend_dispense_ctrl_if.sv | 30 +++
 rtl/vend_stock_counter.sv | 41 ++++
 rtl/vend_dispense_ctrl.sv | 146 ++++++++++++++
 tb/tb_vend_dispense_ctrl.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/vend_pkg.sv
// Shared types and default timing for the vend dispense controller.
package vend_pkg;

  localparam int unsigned VEND_DISPENSE_CYCLES = 8;
  localparam int unsigned VEND_CHANGE_CYCLES   = 4;
  localparam int unsigned VEND_STOCK_W         = 8;
  localparam int unsigned VEND_STOCK_INIT      = 10;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    DISPENSE = 3'd1,
    CHANGE   = 3'd2,
    REFUND   = 3'd3,
    DONE     = 3'd4
  } vend_disp_state_t;

  // One held sale: the vend itself plus whether change is owed.
  typedef struct packed {
    logic vend;
    logic chg;
  } vend_req_t;

  // Bits needed for a down-counter that is loaded with n-1 (at least 1).
  function automatic int unsigned vend_cnt_w(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/vend_dispense_ctrl_if.sv
// Request / actuator bundle between the coin recogniser side and the controller.
interface vend_dispense_ctrl_if #(
  parameter int unsigned STOCK_W = 8
);

  logic               vend_req;
  logic               change_req;
  logic               restock;
  logic [STOCK_W-1:0] restock_qty;

  logic               motor_en;
  logic               change_en;
  logic               refund_en;
  logic               busy;
  logic               done;
  logic               sold_out;
  logic               overrun;
  logic [STOCK_W-1:0] stock;

  modport master (
    output vend_req, change_req, restock, restock_qty,
    input  motor_en, change_en, refund_en, busy, done, sold_out, overrun, stock
  );

  modport slave (
    input  vend_req, change_req, restock, restock_qty,
    output motor_en, change_en, refund_en, busy, done, sold_out, overrun, stock
  );

endinterface

// File: rtl/vend_stock_counter.sv
// Product stock counter: saturating restock add plus a decrement that never
// goes below zero. sold_out is registered from the same next value as stock.
module vend_stock_counter #(
  parameter int unsigned STOCK_W    = 8,
  parameter int unsigned STOCK_INIT = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               add,
  input  logic [STOCK_W-1:0] add_qty,
  input  logic               dec,
  output logic [STOCK_W-1:0] stock,
  output logic               sold_out
);

  localparam int unsigned SUM_W = STOCK_W + 1;
  localparam logic [SUM_W-1:0] STOCK_MAX = {1'b0, {STOCK_W{1'b1}}};

  logic [SUM_W-1:0] sum_c;
  logic [SUM_W-1:0] sat_c;
  logic [SUM_W-1:0] nxt_c;

  // Next stock: saturate the restock first, then take one off for a sale.
  always_comb begin
    sum_c = {1'b0, stock} + (add ? {1'b0, add_qty} : SUM_W'(0));
    sat_c = (sum_c > STOCK_MAX) ? STOCK_MAX : sum_c;
    nxt_c = (dec && (stock != '0)) ? (sat_c - SUM_W'(1)) : sat_c;
  end

  // Stock register and its empty flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      stock    <= STOCK_W'(STOCK_INIT);
      sold_out <= (STOCK_INIT == 0);
    end else begin
      stock    <= nxt_c[STOCK_W-1:0];
      sold_out <= (nxt_c == '0);
    end
  end

endmodule

// File: rtl/vend_dispense_ctrl.sv
// Turns accepted sales into timed motor / change / refund drives, keeps one
// sale in reserve while busy and tracks stock through vend_stock_counter.
module vend_dispense_ctrl
  import vend_pkg::*;
#(
  parameter int unsigned DISPENSE_CYCLES = VEND_DISPENSE_CYCLES,
  parameter int unsigned CHANGE_CYCLES   = VEND_CHANGE_CYCLES,
  parameter int unsigned STOCK_W         = VEND_STOCK_W,
  parameter int unsigned STOCK_INIT      = VEND_STOCK_INIT
) (
  input logic                 clk,
  input logic                 rst,
  vend_dispense_ctrl_if.slave bus
);

  localparam int unsigned TMR_MAX =
    (DISPENSE_CYCLES > CHANGE_CYCLES) ? DISPENSE_CYCLES : CHANGE_CYCLES;
  localparam int unsigned TMR_W = vend_cnt_w(TMR_MAX);
  localparam logic [TMR_W-1:0] DISP_LOAD = TMR_W'(DISPENSE_CYCLES - 1);
  localparam logic [TMR_W-1:0] CHG_LOAD  = TMR_W'(CHANGE_CYCLES - 1);

  vend_disp_state_t state_q, state_d;
  logic [TMR_W-1:0] timer_q, timer_d;
  logic             chg_q, chg_d;
  vend_req_t        pend_q, pend_d;
  logic             overrun_d;
  logic             dec_c;
  logic             start_c;
  logic             start_chg_c;
  logic             take_new_c;

  // Next state, timer, pending slot and stock decrement.
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    chg_d       = chg_q;
    pend_d      = pend_q;
    overrun_d   = 1'b0;
    dec_c       = 1'b0;
    start_c     = 1'b0;
    start_chg_c = 1'b0;
    take_new_c  = 1'b0;

    case (state_q)
      IDLE: begin
        // The held sale goes first; a simultaneous new one refills the slot.
        if (pend_q.vend) begin
          start_c     = 1'b1;
          start_chg_c = pend_q.chg;
          pend_d      = '0;
        end else if (bus.vend_req) begin
          start_c     = 1'b1;
          start_chg_c = bus.change_req;
          take_new_c  = 1'b1;
        end
        if (start_c) begin
          if (!bus.sold_out) begin
            state_d = DISPENSE;
            timer_d = DISP_LOAD;
            chg_d   = start_chg_c;
            dec_c   = 1'b1;
          end else begin
            state_d = REFUND;
            timer_d = CHG_LOAD;
            chg_d   = 1'b0;
          end
        end
      end
      DISPENSE: begin
        if (timer_q == '0) begin
          if (chg_q) begin
            state_d = CHANGE;
            timer_d = CHG_LOAD;
          end else begin
            state_d = DONE;
          end
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      CHANGE, REFUND: begin
        if (timer_q == '0) begin
          state_d = DONE;
        end else begin
          timer_d = timer_q - TMR_W'(1);
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // A request that did not start a sale is held, or dropped if the slot is full.
    if (bus.vend_req && !take_new_c) begin
      if (!pend_d.vend) begin
        pend_d = '{vend: 1'b1, chg: bus.change_req};
      end else begin
        overrun_d = 1'b1;
      end
    end
  end

  // State, timer, pending slot and registered outputs decoded from next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      chg_q         <= 1'b0;
      pend_q        <= '0;
      bus.motor_en  <= 1'b0;
      bus.change_en <= 1'b0;
      bus.refund_en <= 1'b0;
      bus.busy      <= 1'b0;
      bus.done      <= 1'b0;
      bus.overrun   <= 1'b0;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      chg_q         <= chg_d;
      pend_q        <= pend_d;
      bus.motor_en  <= (state_d == DISPENSE);
      bus.change_en <= (state_d == CHANGE);
      bus.refund_en <= (state_d == REFUND);
      bus.busy      <= (state_d != IDLE);
      bus.done      <= (state_d == DONE);
      bus.overrun   <= overrun_d;
    end
  end

  vend_stock_counter #(
    .STOCK_W    (STOCK_W),
    .STOCK_INIT (STOCK_INIT)
  ) u_stock (
    .clk      (clk),
    .rst      (rst),
    .add      (bus.restock),
    .add_qty  (bus.restock_qty),
    .dec      (dec_c),
    .stock    (bus.stock),
    .sold_out (bus.sold_out)
  );

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: directed timelines plus random traffic checked
// against a queue-of-actions model of the sale sequence.
module tb_vend_dispense_ctrl;

  localparam int unsigned DC   = 8;
  localparam int unsigned CC   = 4;
  localparam int unsigned SW   = 8;
  localparam int unsigned SI   = 10;
  localparam int          SMAX = 255;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  vend_dispense_ctrl_if #(.STOCK_W(SW)) bus ();

  vend_dispense_ctrl #(
    .DISPENSE_CYCLES (DC),
    .CHANGE_CYCLES   (CC),
    .STOCK_W         (SW),
    .STOCK_INIT      (SI)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  // Model: each accepted sale expands into a list of per-cycle actions.
  typedef enum int {A_IDLE, A_MOTOR, A_CHANGE, A_REFUND, A_DONE} act_t;
  act_t m_cur;
  act_t m_q[$];
  bit   m_pend;
  bit   m_pend_chg;
  bit   m_over;
  int   m_stock;

  // Drive one cycle of inputs, advance the model at the edge, settle past it.
  task automatic step(input bit v, input bit c, input bit r, input int q, input bit rs);
    bit start;
    bit s_chg;
    bit used;
    int nxt;
    bus.vend_req    = v;
    bus.change_req  = c;
    bus.restock     = r;
    bus.restock_qty = SW'(q);
    rst             = rs;
    @(posedge clk);
    if (rs) begin
      m_cur = A_IDLE;
      m_q.delete();
      m_pend = 0;
      m_pend_chg = 0;
      m_over = 0;
      m_stock = SI;
    end else begin
      start = 0;
      s_chg = 0;
      used  = 0;
      m_over = 0;
      if (m_cur == A_IDLE) begin
        if (m_pend) begin
          start = 1; s_chg = m_pend_chg; m_pend = 0;
        end else if (v) begin
          start = 1; s_chg = c; used = 1;
        end
      end
      if (v && !used) begin
        if (!m_pend) begin m_pend = 1; m_pend_chg = c; end
        else m_over = 1;
      end
      nxt = m_stock + (r ? q : 0);
      if (nxt > SMAX) nxt = SMAX;
      if (start) begin
        if (m_stock > 0) begin
          repeat (DC) m_q.push_back(A_MOTOR);
          if (s_chg) repeat (CC) m_q.push_back(A_CHANGE);
          nxt = nxt - 1;
        end else begin
          repeat (CC) m_q.push_back(A_REFUND);
        end
        m_q.push_back(A_DONE);
      end
      m_stock = nxt;
      m_cur = (m_q.size() > 0) ? m_q.pop_front() : A_IDLE;
    end
    #1;
  endtask

  task automatic test_reset();
    step(0, 0, 0, 0, 1);
    n_checks++; if (bus.motor_en  !== 1'b0) $display("FAIL reset motor_en got %b want 0", bus.motor_en); else n_pass++;
    n_checks++; if (bus.change_en !== 1'b0) $display("FAIL reset change_en got %b want 0", bus.change_en); else n_pass++;
    n_checks++; if (bus.refund_en !== 1'b0) $display("FAIL reset refund_en got %b want 0", bus.refund_en); else n_pass++;
    n_checks++; if (bus.busy      !== 1'b0) $display("FAIL reset busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.done      !== 1'b0) $display("FAIL reset done got %b want 0", bus.done); else n_pass++;
    n_checks++; if (bus.overrun   !== 1'b0) $display("FAIL reset overrun got %b want 0", bus.overrun); else n_pass++;
    n_checks++; if (bus.stock !== SW'(SI)) $display("FAIL reset stock got %0d want %0d", bus.stock, SI); else n_pass++;
    n_checks++; if (bus.sold_out  !== 1'b0) $display("FAIL reset sold_out got %b want 0", bus.sold_out); else n_pass++;
    step(0, 0, 0, 0, 0);
  endtask

  task automatic test_sale_nochg();
    logic em, ed, eb;
    step(1, 0, 0, 0, 0);
    for (int k = 1; k <= 10; k++) begin
      em = (k >= 1 && k <= 8);
      ed = (k == 9);
      eb = (k <= 9);
      n_checks++; if (bus.motor_en !== em) $display("FAIL sale_nochg motor_en cyc %0d got %b want %b", k, bus.motor_en, em); else n_pass++;
      n_checks++; if (bus.done !== ed) $display("FAIL sale_nochg done cyc %0d got %b want %b", k, bus.done, ed); else n_pass++;
      n_checks++; if (bus.busy !== eb) $display("FAIL sale_nochg busy cyc %0d got %b want %b", k, bus.busy, eb); else n_pass++;
      n_checks++; if (bus.stock !== SW'(9)) $display("FAIL sale_nochg stock cyc %0d got %0d want 9", k, bus.stock); else n_pass++;
      step(0, 0, 0, 0, 0);
    end
  endtask

  task automatic test_sale_chg();
    logic em, ec, ed;
    step(1, 1, 0, 0, 0);
    for (int k = 1; k <= 14; k++) begin
      em = (k >= 1 && k <= 8);
      ec = (k >= 9 && k <= 12);
      ed = (k == 13);
      n_checks++; if (bus.motor_en !== em) $display("FAIL sale_chg motor_en cyc %0d got %b want %b", k, bus.motor_en, em); else n_pass++;
      n_checks++; if (bus.change_en !== ec) $display("FAIL sale_chg change_en cyc %0d got %b want %b", k, bus.change_en, ec); else n_pass++;
      n_checks++; if (bus.done !== ed) $display("FAIL sale_chg done cyc %0d got %b want %b", k, bus.done, ed); else n_pass++;
      n_checks++; if ((bus.motor_en & bus.change_en) !== 1'b0) $display("FAIL sale_chg exclusive cyc %0d got motor %b change %b", k, bus.motor_en, bus.change_en); else n_pass++;
      step(0, 0, 0, 0, 0);
    end
    n_checks++; if (bus.stock !== SW'(8)) $display("FAIL sale_chg stock got %0d want 8", bus.stock); else n_pass++;
  endtask

  task automatic test_back_to_back();
    logic em, ed, eo;
    int s0;
    s0 = int'(bus.stock);
    for (int k = 0; k <= 22; k++) begin
      step((k == 0 || k == 3 || k == 5), 0, 0, 0, 0);
      em = ((k + 1) >= 1 && (k + 1) <= 8) || ((k + 1) >= 11 && (k + 1) <= 18);
      ed = ((k + 1) == 9) || ((k + 1) == 19);
      eo = ((k + 1) == 6);
      n_checks++; if (bus.motor_en !== em) $display("FAIL b2b motor_en cyc %0d got %b want %b", k + 1, bus.motor_en, em); else n_pass++;
      n_checks++; if (bus.done !== ed) $display("FAIL b2b done cyc %0d got %b want %b", k + 1, bus.done, ed); else n_pass++;
      n_checks++; if (bus.overrun !== eo) $display("FAIL b2b overrun cyc %0d got %b want %b", k + 1, bus.overrun, eo); else n_pass++;
    end
    n_checks++; if (bus.stock !== SW'(s0 - 2)) $display("FAIL b2b stock got %0d want %0d", bus.stock, s0 - 2); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL b2b busy_end got %b want 0", bus.busy); else n_pass++;
  endtask

  task automatic test_restock_sat();
    step(0, 0, 1, 250 - int'(bus.stock), 0);
    n_checks++; if (bus.stock !== SW'(250)) $display("FAIL restock stock_250 got %0d want 250", bus.stock); else n_pass++;
    step(1, 0, 1, 10, 0);
    n_checks++; if (bus.stock !== SW'(254)) $display("FAIL restock add_and_sale got %0d want 254", bus.stock); else n_pass++;
    n_checks++; if (bus.motor_en !== 1'b1) $display("FAIL restock motor_en got %b want 1", bus.motor_en); else n_pass++;
    repeat (10) step(0, 0, 0, 0, 0);
    step(0, 0, 1, 10, 0);
    n_checks++; if (bus.stock !== SW'(255)) $display("FAIL restock saturate got %0d want 255", bus.stock); else n_pass++;
    step(0, 0, 1, 1, 0);
    n_checks++; if (bus.stock !== SW'(255)) $display("FAIL restock hold_max got %0d want 255", bus.stock); else n_pass++;
  endtask

  task automatic test_reset_mid();
    step(0, 0, 0, 0, 1);
    step(1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0);
    n_checks++; if (bus.motor_en !== 1'b1) $display("FAIL reset_mid motor_before got %b want 1", bus.motor_en); else n_pass++;
    n_checks++; if (bus.stock !== SW'(SI - 1)) $display("FAIL reset_mid stock_before got %0d want %0d", bus.stock, SI - 1); else n_pass++;
    step(0, 0, 0, 0, 1);
    n_checks++; if (bus.motor_en !== 1'b0) $display("FAIL reset_mid motor_en got %b want 0", bus.motor_en); else n_pass++;
    n_checks++; if (bus.busy !== 1'b0) $display("FAIL reset_mid busy got %b want 0", bus.busy); else n_pass++;
    n_checks++; if (bus.stock !== SW'(SI)) $display("FAIL reset_mid stock got %0d want %0d", bus.stock, SI); else n_pass++;
    for (int k = 0; k < 15; k++) begin
      step(0, 0, 0, 0, 0);
      n_checks++; if ((bus.busy | bus.done | bus.motor_en) !== 1'b0) $display("FAIL reset_mid quiet cyc %0d got busy %b done %b motor %b", k, bus.busy, bus.done, bus.motor_en); else n_pass++;
    end
  endtask

  task automatic test_sold_out();
    for (int s = 0; s < int'(SI); s++) begin
      step(1, 0, 0, 0, 0);
      repeat (9) step(0, 0, 0, 0, 0);
    end
    n_checks++; if (bus.stock !== SW'(0)) $display("FAIL sold_out drained stock got %0d want 0", bus.stock); else n_pass++;
    n_checks++; if (bus.sold_out !== 1'b1) $display("FAIL sold_out flag got %b want 1", bus.sold_out); else n_pass++;
    step(1, 1, 0, 0, 0);
    for (int k = 1; k <= 6; k++) begin
      n_checks++; if (bus.refund_en !== (k <= 4)) $display("FAIL sold_out refund_en cyc %0d got %b want %b", k, bus.refund_en, (k <= 4)); else n_pass++;
      n_checks++; if ((bus.motor_en | bus.change_en) !== 1'b0) $display("FAIL sold_out no_motor cyc %0d got motor %b change %b", k, bus.motor_en, bus.change_en); else n_pass++;
      n_checks++; if (bus.done !== (k == 5)) $display("FAIL sold_out done cyc %0d got %b want %b", k, bus.done, (k == 5)); else n_pass++;
      step(0, 0, 0, 0, 0);
    end
    n_checks++; if (bus.stock !== SW'(0)) $display("FAIL sold_out stock_after got %0d want 0", bus.stock); else n_pass++;
    step(0, 0, 1, 3, 0);
    n_checks++; if (bus.sold_out !== 1'b0 || bus.stock !== SW'(3)) $display("FAIL sold_out refill got sold_out %b stock %0d want 0 3", bus.sold_out, bus.stock); else n_pass++;
  endtask

  task automatic test_random();
    bit v, c, r, rs;
    int q;
    step(0, 0, 0, 0, 1);
    for (int n = 0; n < 4000; n++) begin
      v  = ($urandom_range(0, 5) == 0);
      c  = $urandom_range(0, 1) == 1;
      r  = ($urandom_range(0, 63) == 0);
      q  = ($urandom_range(0, 19) == 0) ? int'($urandom_range(200, 255)) : int'($urandom_range(0, 8));
      rs = ($urandom_range(0, 499) == 0);
      step(v, c, r, q, rs);
      n_checks++; if (bus.motor_en !== (m_cur == A_MOTOR)) $display("FAIL rand motor_en n %0d got %b want %b", n, bus.motor_en, (m_cur == A_MOTOR)); else n_pass++;
      n_checks++; if (bus.change_en !== (m_cur == A_CHANGE)) $display("FAIL rand change_en n %0d got %b want %b", n, bus.change_en, (m_cur == A_CHANGE)); else n_pass++;
      n_checks++; if (bus.refund_en !== (m_cur == A_REFUND)) $display("FAIL rand refund_en n %0d got %b want %b", n, bus.refund_en, (m_cur == A_REFUND)); else n_pass++;
      n_checks++; if (bus.done !== (m_cur == A_DONE)) $display("FAIL rand done n %0d got %b want %b", n, bus.done, (m_cur == A_DONE)); else n_pass++;
      n_checks++; if (bus.busy !== (m_cur != A_IDLE)) $display("FAIL rand busy n %0d got %b want %b", n, bus.busy, (m_cur != A_IDLE)); else n_pass++;
      n_checks++; if (bus.overrun !== m_over) $display("FAIL rand overrun n %0d got %b want %b", n, bus.overrun, m_over); else n_pass++;
      n_checks++; if (bus.stock !== SW'(m_stock)) $display("FAIL rand stock n %0d got %0d want %0d", n, bus.stock, m_stock); else n_pass++;
      n_checks++; if (bus.sold_out !== (m_stock == 0)) $display("FAIL rand sold_out n %0d got %b want %b", n, bus.sold_out, (m_stock == 0)); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_sale_nochg();
    test_sale_chg();
    test_back_to_back();
    test_restock_sat();
    test_reset_mid();
    test_sold_out();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
